// File: rtl/tqv_spi_host.sv
// SPI initiator for the TinyQV peripheral register interface: 32-bit header,
// optional read turnaround, then 8/16/32 data bits, SPI mode 0.
module tqv_spi_host #(
  parameter int CLK_DIV         = 4,
  parameter int READ_DUMMY_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_width,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, HDR, DUMMY, DATA, CS_HOLD, CS_GAP
  } state_t;

  localparam logic [8:0] HALF_LD    = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LD     = 9'(2 * CLK_DIV - 1);
  localparam logic [5:0] DUMMY_LD   = 6'(READ_DUMMY_BITS);
  localparam bit         SKIP_DUMMY = (READ_DUMMY_BITS == 0);

  function automatic logic [5:0] data_bits(input logic [1:0] width);
    case (width)
      2'd0:    data_bits = 6'd8;
      2'd1:    data_bits = 6'd16;
      default: data_bits = 6'd32;
    endcase
  endfunction

  // Left-align write data so the MSB of the active field sits at bit 31.
  function automatic logic [31:0] align_wdata(input logic [1:0] width, input logic [31:0] wdata);
    case (width)
      2'd0:    align_wdata = {wdata[7:0], 24'b0};
      2'd1:    align_wdata = {wdata[15:0], 16'b0};
      default: align_wdata = wdata;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [5:0]  bits_q, bits_d;
  logic [5:0]  nbits_q, nbits_d;
  logic        write_q, write_d;
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] wd_q, wd_d;
  logic        miso_s1_q, miso_s2_q;
  logic [1:0]  hdr_width;
  logic [31:0] hdr;
  logic        cnt_zero;

  assign hdr_width = (cmd_width == 2'b11) ? 2'b10 : cmd_width;
  assign hdr       = {cmd_write, hdr_width, 23'b0, cmd_addr};
  assign cnt_zero  = (cnt_q == 9'd0);

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign spi_cs_n  = cs_n_q;
  assign spi_sck   = sck_q;
  assign spi_mosi  = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bits_d      = bits_q;
    nbits_d     = nbits_q;
    write_d     = write_q;
    sck_d       = sck_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    wd_d        = wd_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d = CS_SETUP;
          cnt_d   = HALF_LD;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          write_d = cmd_write;
          nbits_d = data_bits(cmd_width);
          wd_d    = align_wdata(cmd_width, cmd_wdata);
          tx_d    = hdr;
          mosi_d  = hdr[31];
          rx_d    = '0;
        end
      end
      CS_SETUP: begin
        if (cnt_zero) begin
          state_d = HDR;
          bits_d  = 6'd32;
          sck_d   = 1'b1;
          cnt_d   = HALF_LD;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      HDR, DUMMY, DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 9'd1;
        end else if (sck_q) begin
          // Falling SCK: present the next MOSI bit and capture MISO.
          sck_d = 1'b0;
          cnt_d = HALF_LD;
          if (state_q == HDR && bits_q == 6'd1 && write_q) tx_d = wd_q;
          else tx_d = {tx_q[30:0], 1'b0};
          mosi_d = tx_d[31];
          if (state_q == DATA) rx_d = {rx_q[30:0], miso_s2_q};
        end else begin
          cnt_d = HALF_LD;
          if (bits_q == 6'd1) begin
            case (state_q)
              HDR: begin
                sck_d = 1'b1;
                if (write_q || SKIP_DUMMY) begin
                  state_d = DATA;
                  bits_d  = nbits_q;
                end else begin
                  state_d = DUMMY;
                  bits_d  = DUMMY_LD;
                end
              end
              DUMMY: begin
                state_d = DATA;
                bits_d  = nbits_q;
                sck_d   = 1'b1;
              end
              default: state_d = CS_HOLD;
            endcase
          end else begin
            bits_d = bits_q - 6'd1;
            sck_d  = 1'b1;
          end
        end
      end
      CS_HOLD: begin
        if (cnt_zero) begin
          state_d     = CS_GAP;
          cs_n_d      = 1'b1;
          cnt_d       = GAP_LD;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? 32'h0 : rx_q;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end
      CS_GAP: begin
        if (cnt_zero) state_d = IDLE;
        else cnt_d = cnt_q - 9'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bits_q      <= '0;
      nbits_q     <= '0;
      write_q     <= 1'b0;
      sck_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      nbits_q     <= nbits_d;
      write_q     <= write_d;
      sck_q       <= sck_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_q      <= tx_d;
    rx_q      <= rx_d;
    wd_q      <= wd_d;
    miso_s1_q <= spi_miso;
    miso_s2_q <= miso_s1_q;
  end

endmodule

// File: tb/tb_tqv_spi_host.sv
// Bench for tqv_spi_host: two instances (default timing, and CLK_DIV=3 with
// no turnaround) driven against a behavioural SPI responder each.
module tb_tqv_spi_host;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: CLK_DIV=4, READ_DUMMY_BITS=8
  logic        cmd_valid_a = 1'b0, cmd_write_a = 1'b0;
  logic [1:0]  cmd_width_a = 2'd0;
  logic [5:0]  cmd_addr_a = 6'd0;
  logic [31:0] cmd_wdata_a = 32'd0;
  logic        cmd_ready_a, rsp_valid_a, busy_a, cs_n_a, sck_a, mosi_a;
  logic [31:0] rsp_rdata_a;
  logic        miso_a = 1'b0;

  // Instance B: CLK_DIV=3, READ_DUMMY_BITS=0
  logic        cmd_valid_b = 1'b0, cmd_write_b = 1'b0;
  logic [1:0]  cmd_width_b = 2'd0;
  logic [5:0]  cmd_addr_b = 6'd0;
  logic [31:0] cmd_wdata_b = 32'd0;
  logic        cmd_ready_b, rsp_valid_b, busy_b, cs_n_b, sck_b, mosi_b;
  logic [31:0] rsp_rdata_b;
  logic        miso_b = 1'b0;

  tqv_spi_host #(.CLK_DIV(4), .READ_DUMMY_BITS(8)) dut_a (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_write(cmd_write_a),
    .cmd_width(cmd_width_a), .cmd_addr(cmd_addr_a), .cmd_wdata(cmd_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .busy(busy_a),
    .spi_cs_n(cs_n_a), .spi_sck(sck_a), .spi_mosi(mosi_a), .spi_miso(miso_a)
  );

  tqv_spi_host #(.CLK_DIV(3), .READ_DUMMY_BITS(0)) dut_b (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write_b),
    .cmd_width(cmd_width_b), .cmd_addr(cmd_addr_b), .cmd_wdata(cmd_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .busy(busy_b),
    .spi_cs_n(cs_n_b), .spi_sck(sck_b), .spi_mosi(mosi_b), .spi_miso(miso_b)
  );

  // Responder A: records MOSI on SCK rise, drives MISO after SCK fall.
  int           rise_a = 0;
  int           nbits_a = 8;
  int           rsp_cnt_a = 0;
  int           csfall_a = 0;
  logic [127:0] cap_a = '0;
  logic [31:0]  word_a = '0;

  always @(negedge cs_n_a) begin
    rise_a = 0;
    cap_a = '0;
    csfall_a = csfall_a + 1;
  end
  always @(posedge sck_a) if (!cs_n_a) begin
    cap_a = {cap_a[126:0], mosi_a};
    rise_a = rise_a + 1;
  end
  always @(negedge sck_a) if (!cs_n_a && rise_a >= 40 && rise_a < 40 + nbits_a)
    miso_a = word_a[nbits_a - 1 - (rise_a - 40)];
  always @(negedge clk) if (rsp_valid_a) rsp_cnt_a = rsp_cnt_a + 1;

  // Responder B: no turnaround, data follows the header immediately.
  int           rise_b = 0;
  int           nbits_b = 8;
  logic [127:0] cap_b = '0;
  logic [31:0]  word_b = '0;
  longint       first_b = 0, last_b = 0;

  always @(negedge cs_n_b) begin
    rise_b = 0;
    cap_b = '0;
  end
  always @(posedge sck_b) if (!cs_n_b) begin
    if (rise_b == 0) first_b = $time;
    last_b = $time;
    cap_b = {cap_b[126:0], mosi_b};
    rise_b = rise_b + 1;
  end
  always @(negedge sck_b) if (!cs_n_b && rise_b >= 32 && rise_b < 32 + nbits_b)
    miso_b = word_b[nbits_b - 1 - (rise_b - 32)];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  width;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] word;
    int          nb;
    logic [31:0] hdr;
    int          sck;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  task automatic wait_ready_a(input string name);
    int k = 0;
    while (!cmd_ready_a && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'b0, cmd_ready_a}, 32'd1);
  endtask

  task automatic run_a(input int idx, input vec_t v);
    int cnt = 0;
    bit seen = 1'b0;
    logic [31:0] mask;
    logic [31:0] held;
    mask = (v.nb == 32) ? 32'hFFFF_FFFF : ((32'h1 << v.nb) - 32'h1);
    word_a = v.word;
    nbits_a = v.nb;
    wait_ready_a($sformatf("v%0d_ready", idx));
    cmd_write_a = v.wr;
    cmd_width_a = v.width;
    cmd_addr_a  = v.addr;
    cmd_wdata_a = v.wdata;
    cmd_valid_a = 1'b1;
    while (cnt < 3000 && !seen) begin
      @(negedge clk);
      cnt++;
      cmd_valid_a = 1'b0;
      cmd_wdata_a = ~v.wdata;
      if (rsp_valid_a) seen = 1'b1;
    end
    chk($sformatf("v%0d_latency", idx), seen ? cnt : -1, v.lat);
    chk($sformatf("v%0d_sck_pulses", idx), rise_a, v.sck);
    chk($sformatf("v%0d_header", idx), cap_a[v.sck-1 -: 32], v.hdr);
    if (v.wr) chk($sformatf("v%0d_mosi_data", idx), cap_a[31:0] & mask, v.wdata & mask);
    else      chk($sformatf("v%0d_dummy_zero", idx), {24'b0, cap_a[v.nb +: 8]}, 32'd0);
    chk($sformatf("v%0d_rdata", idx), rsp_rdata_a, v.rdata);
    held = rsp_rdata_a;
    @(negedge clk);
    chk($sformatf("v%0d_rsp_pulse", idx), {31'b0, rsp_valid_a}, 32'd0);
    chk($sformatf("v%0d_rdata_held", idx), rsp_rdata_a, v.rdata);
  endtask

  initial begin
    int cnt;
    int gap;
    int base_rsp;
    int base_fall;
    bit seen;

    vecs[0] = '{1'b1, 2'd0, 6'h05, 32'h0000_00A5, 32'h0,         8,  32'h8000_0005, 40, 32'h0,         329};
    vecs[1] = '{1'b0, 2'd2, 6'h3F, 32'h0,         32'hDEAD_BEEF, 32, 32'h4000_003F, 72, 32'hDEAD_BEEF, 585};
    vecs[2] = '{1'b0, 2'd1, 6'h12, 32'h0,         32'hFFFF_1234, 16, 32'h2000_0012, 56, 32'h0000_1234, 457};
    vecs[3] = '{1'b0, 2'd3, 6'h01, 32'h0,         32'hCAFE_F00D, 32, 32'h4000_0001, 72, 32'hCAFE_F00D, 585};
    vecs[4] = '{1'b1, 2'd1, 6'h2A, 32'hFFFF_BEEF, 32'h0,         16, 32'hA000_002A, 48, 32'h0,         393};
    vecs[5] = '{1'b1, 2'd2, 6'h00, 32'h1234_5678, 32'h0,         32, 32'hC000_0000, 64, 32'h0,         521};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready_a}, 32'd0);
    chk("rst_cs_n", {31'b0, cs_n_a}, 32'd1);
    chk("rst_sck", {31'b0, sck_a}, 32'd0);
    chk("rst_mosi", {31'b0, mosi_a}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid_a}, 32'd0);
    chk("rst_rdata", rsp_rdata_a, 32'd0);
    chk("rst_busy", {31'b0, busy_a}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready_a", {31'b0, cmd_ready_a}, 32'd1);
    chk("post_rst_ready_b", {31'b0, cmd_ready_b}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_a(i, vecs[i]);

    // Back-to-back with cmd_valid held high
    wait_ready_a("b2b_ready");
    word_a = 32'h0; nbits_a = 8;
    cmd_write_a = 1'b1; cmd_width_a = 2'd0; cmd_addr_a = 6'h05; cmd_wdata_a = 32'hA5;
    cmd_valid_a = 1'b1;
    cnt = 0; seen = 1'b0;
    while (cnt < 3000 && !seen) begin
      @(negedge clk);
      cnt++;
      if (rsp_valid_a) seen = 1'b1;
    end
    chk("b2b_first_rsp", {31'b0, seen}, 32'd1);
    gap = 1;
    while (gap < 100) begin
      @(negedge clk);
      if (cs_n_a) gap++;
      else break;
    end
    chk("b2b_cs_gap", gap, 32'd9);
    cmd_valid_a = 1'b0;
    cnt = 0; seen = 1'b0;
    while (cnt < 3000 && !seen) begin
      @(negedge clk);
      cnt++;
      if (rsp_valid_a) seen = 1'b1;
    end
    chk("b2b_second_latency", seen ? cnt : -1, 328);
    chk("b2b_second_header", cap_a[39:8], 32'h8000_0005);

    // cmd_valid pulses during HDR are dropped, not queued
    wait_ready_a("drop_ready");
    base_rsp = rsp_cnt_a;
    base_fall = csfall_a;
    cmd_write_a = 1'b1; cmd_width_a = 2'd1; cmd_addr_a = 6'h11; cmd_wdata_a = 32'h5A5A;
    cmd_valid_a = 1'b1;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    cnt = 0;
    while (rise_a < 5 && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    cmd_addr_a = 6'h22; cmd_wdata_a = 32'h1111;
    cmd_valid_a = 1'b1;
    repeat (2) @(negedge clk);
    cmd_valid_a = 1'b0;
    wait_ready_a("drop_done");
    chk("drop_header", cap_a[47:16], 32'hA000_0011);
    chk("drop_mosi_data", {16'b0, cap_a[15:0]}, 32'h5A5A);
    repeat (40) @(negedge clk);
    chk("drop_rsp_count", rsp_cnt_a - base_rsp, 32'd1);
    chk("drop_cs_count", csfall_a - base_fall, 32'd1);

    // Asynchronous reset in the middle of DATA
    word_a = 32'h0; nbits_a = 32;
    cmd_write_a = 1'b1; cmd_width_a = 2'd2; cmd_addr_a = 6'h0A; cmd_wdata_a = 32'h0F0F_0F0F;
    cmd_valid_a = 1'b1;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    cnt = 0;
    while (!(rise_a >= 40 && sck_a) && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    chk("mid_rst_in_data", {31'b0, sck_a & busy_a}, 32'd1);
    base_rsp = rsp_cnt_a;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_cs_n", {31'b0, cs_n_a}, 32'd1);
    chk("mid_rst_sck", {31'b0, sck_a}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy_a}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, cmd_ready_a}, 32'd1);
    chk("mid_rst_rdata", rsp_rdata_a, 32'd0);
    repeat (20) @(negedge clk);
    chk("mid_rst_no_rsp", rsp_cnt_a - base_rsp, 32'd0);
    run_a(6, vecs[1]);

    // CLK_DIV=3, no turnaround, 8-bit read
    word_b = 32'h0000_005C; nbits_b = 8;
    cmd_write_b = 1'b0; cmd_width_b = 2'd0; cmd_addr_b = 6'h07; cmd_wdata_b = 32'h0;
    cmd_valid_b = 1'b1;
    cnt = 0; seen = 1'b0;
    while (cnt < 3000 && !seen) begin
      @(negedge clk);
      cnt++;
      cmd_valid_b = 1'b0;
      if (rsp_valid_b) seen = 1'b1;
    end
    chk("b_latency", seen ? cnt : -1, 247);
    chk("b_sck_pulses", rise_b, 32'd40);
    chk("b_sck_period", 32'(last_b - first_b), 32'd2340);
    chk("b_header", cap_b[39:8], 32'h0000_0007);
    chk("b_rdata", rsp_rdata_b, 32'h0000_005C);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
